// File: rtl/note_sequencer.sv
// Note recorder/player with bookmarks and a write-protect base mark.
// Define NOTE_SEQUENCER_LOOP_EN to loop playback back to mark[0] at end of track.
module note_sequencer #(
  parameter int WORD_SIZE = 69,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 65000,
  parameter int NUM_MARKS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] key,
  input  logic                 tick,
  input  logic                 rec,
  input  logic                 play,
  input  logic [NUM_MARKS-1:0] mark_sel,
  input  logic                 mark_set,
  output logic [WORD_SIZE-1:0] note,
  output logic [ADDR_W-1:0]    pc,
  output logic [1:0]           state,
  output logic                 full
);

  localparam int IDX_W = $clog2(NUM_MARKS);
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_REC  = 2'b10
  } st_e;

  st_e                  st;
  st_e                  st_nxt;
  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]    marks [NUM_MARKS];
  logic [ADDR_W:0]      end_ptr;
  logic [ADDR_W:0]      pc_inc;
  logic [ADDR_W-1:0]    loop_pc;
  logic [IDX_W-1:0]     sel_idx;
  logic                 lock;
  logic                 jump;
  logic                 store;
  logic                 rec_tick;
  logic                 wr_en;
  logic                 at_last;
  logic                 eot;

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_MARKS - 1; i >= 0; i--) begin
      if (mark_sel[i]) sel_idx = IDX_W'(i);
    end
  end

  assign jump     = (|mark_sel) & ~mark_set;
  assign store    = (|mark_sel) & mark_set;
  assign pc_inc   = {1'b0, pc} + {{ADDR_W{1'b0}}, 1'b1};
  assign at_last  = (pc == LAST);
  assign rec_tick = (st == S_REC) & tick;
  assign wr_en    = rec_tick & ~reset & (pc >= marks[NUM_MARKS-1]);
  assign eot      = (st == S_PLAY) & tick & (pc_inc >= end_ptr);
  assign loop_pc  = ({1'b0, marks[0]} < end_ptr) ? marks[0] : '0;
  assign state    = st;
  assign full     = (end_ptr == DEPTH_W);

  // A filled track keeps rec locked out until the switch is cycled.
  always_comb begin
    st_nxt = S_IDLE;
    if (rec) begin
      st_nxt = lock ? S_IDLE : S_REC;
    end else if (play && end_ptr != '0) begin
      st_nxt = S_PLAY;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[pc] <= key;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= S_IDLE;
      pc      <= '0;
      note    <= '0;
      end_ptr <= '0;
      lock    <= 1'b0;
      for (int i = 0; i < NUM_MARKS; i++) marks[i] <= '0;
    end else begin
      st   <= st_nxt;
      lock <= lock & rec;
      if (store) marks[sel_idx] <= pc;
      if (wr_en && pc_inc > end_ptr) end_ptr <= pc_inc;
      if (rec_tick && at_last) begin
        lock <= 1'b1;
        st   <= S_IDLE;
      end
      if (jump) begin
        pc <= marks[sel_idx];
      end else if (tick) begin
        case (st)
          S_REC: if (!at_last) pc <= pc + 1'b1;
          S_PLAY: begin
            if (eot) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
              pc <= loop_pc;
`else
              pc <= '0;
              if (st_nxt != S_REC) st <= S_IDLE;
`endif
            end else begin
              pc <= pc + 1'b1;
            end
          end
          default: ;
        endcase
      end
      case (st)
        S_REC:   note <= key;
        S_PLAY:  note <= mem[pc];
        default: note <= '0;
      endcase
    end
  end

endmodule
